wb_gpio_in: RTL

Wishbone B4 classic slave that samples up to 32 external input pins, detects per-bit edges of programmable polarity, and raises a level interrupt toward the picorv32 `irq` vector. It is the input-direction counterpart to `wb_leds` on the same shared bus. It attaches to `wb_intercon` as a slave port, and `irq_o` is wired to one `irq_i` bit of the system top.

---
 rtl/wb_gpio_in_if.sv | 29 ++
 rtl/wb_gpio_in.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_in_if.sv
// Wishbone B4 classic bus bundle between wb_intercon and the wb_gpio_in slave.
//   cyc/stb/we  : cycle, strobe, write enable (master -> slave)
//   adr         : byte address (master -> slave)
//   dat_w/sel   : write data and byte lanes (master -> slave)
//   dat_r/ack   : read data and acknowledge (slave -> master)
interface wb_gpio_in_if;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = DAT_W / 8;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_r;
  logic             ack;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_gpio_in.sv
// Wishbone B4 classic GPIO input slave: synchronizes external pins, latches
// per-bit edge events of programmable polarity into a W1C status register and
// drives a registered level interrupt.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wb             : Wishbone slave port (wb_gpio_in_if.slave)
//   gpio_i         : asynchronous external inputs
//   irq_o          : level interrupt, |(STATUS & IRQ_EN), registered
// Register map (adr[3:2]): 0 DATA (RO), 1 IRQ_EN, 2 EDGE_POL, 3 STATUS (W1C).
// Optional macro WB_GPIO_IN_DEBOUNCE_EN adds a tick-sampled two-agreeing-sample
// filter (period DEBOUNCE_DIV clocks) between the synchronizer and DATA.
module wb_gpio_in #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEBOUNCE_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  wb_gpio_in_if.slave      wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic             irq_o
);

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned LANE_N = BUS_W / 8;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_IRQ_EN = 2'd1;
  localparam logic [1:0] ADR_POL    = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] gpio_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] edge_pol;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] events;

  logic             req;
  logic             wr;
  logic [1:0]       reg_sel;
  logic [BUS_W-1:0] lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] irq_en_next;
  logic [WIDTH-1:0] edge_pol_next;
  logic [BUS_W-1:0] rdata;

  // Bus decode: a new transfer is accepted only when ack is not already high.
  assign req     = wb.cyc & wb.stb & ~wb.ack;
  assign wr      = req & wb.we;
  assign reg_sel = wb.adr[3:2];

  // Byte-lane expansion of sel into a bit mask.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < int'(LANE_N); i++) begin
      lane_mask[8*i +: 8] = {8{wb.sel[i]}};
    end
  end

  assign wmask = WIDTH'(lane_mask);
  assign wdata = WIDTH'(wb.dat_w);

  // Next values of the writable registers; only selected lanes change.
  always_comb begin
    irq_en_next   = irq_en;
    edge_pol_next = edge_pol;
    status_clr    = '0;
    if (wr) begin
      unique case (reg_sel)
        ADR_IRQ_EN: irq_en_next   = (irq_en & ~wmask) | (wdata & wmask);
        ADR_POL:    edge_pol_next = (edge_pol & ~wmask) | (wdata & wmask);
        ADR_STATUS: status_clr    = wdata & wmask;
        default:    ;
      endcase
    end
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      ADR_DATA:   rdata = BUS_W'(gpio_q);
      ADR_IRQ_EN: rdata = BUS_W'(irq_en);
      ADR_POL:    rdata = BUS_W'(edge_pol);
      ADR_STATUS: rdata = BUS_W'(status);
      default:    rdata = '0;
    endcase
  end

`ifdef WB_GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_DIV);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [WIDTH-1:0] samp;

  assign tick = (div_cnt == CNT_W'(DEBOUNCE_DIV - 1));

  // Free-running tick divider and per-tick sample of the synchronized pins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
      samp    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) begin
        samp <= sync1;
      end
    end
  end

  // A bit moves only when two consecutive tick samples agree.
  always_comb begin
    q_next = gpio_q;
    if (tick) begin
      q_next = ((sync1 ~^ samp) & sync1) | ((sync1 ^ samp) & gpio_q);
    end
  end
`else
  logic [31:0] unused_div;
  assign unused_div = 32'(DEBOUNCE_DIV);

  assign q_next = sync1;
`endif

  // Edge events relative to the current DATA value, qualified by polarity.
  assign events = (q_next & ~gpio_q & edge_pol) | (~q_next & gpio_q & ~edge_pol);

  // Synchronizer, registers, bus response and interrupt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync0    <= '0;
      sync1    <= '0;
      gpio_q   <= '0;
      irq_en   <= '0;
      edge_pol <= '0;
      status   <= '0;
      wb.ack   <= 1'b0;
      wb.dat_r <= '0;
      irq_o    <= 1'b0;
    end else begin
      sync0    <= gpio_i;
      sync1    <= sync0;
      gpio_q   <= q_next;
      irq_en   <= irq_en_next;
      edge_pol <= edge_pol_next;
      // Set beats clear when an event and a W1C hit the same bit.
      status   <= (status & ~status_clr) | events;
      wb.ack   <= req;
      if (req) begin
        wb.dat_r <= rdata;
      end
      irq_o    <= |(status & irq_en);
    end
  end

  logic unused_bus;
  assign unused_bus = ^{wb.adr[31:4], wb.adr[1:0], wb.dat_w};

endmodule
